// File: rtl/table_load_pkg.sv
// table_load_pkg: shared state encoding, symbol width and index-width helper for the table loader.
package table_load_pkg;

    localparam int ASCII_W = 8;

    typedef enum logic [1:0] {IDLE, FILL, START, WAIT} loadState;

    function automatic int clog2(input int n);
        int r;
        for (r = 0; (1 << r) < n; r++) begin
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/table_load_lanes.sv
// table_load_lanes: lane register file feeding the TableBuilder write bus.
// TABLE_LOAD_CTRL_DEDUP_EN adds a parallel compare of din against all enabled lanes.
module table_load_lanes
    import table_load_pkg::*;
#(
    parameter int NUM_LANES = 6,
    parameter int SLOT_W = clog2(NUM_LANES)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           we,
    input  logic [SLOT_W-1:0]              slot,
    input  logic [ASCII_W-1:0]             din,
    input  logic                           clr,
    output logic [NUM_LANES-1:0]           wrEn,
    output logic [NUM_LANES*ASCII_W-1:0]   data
`ifdef TABLE_LOAD_CTRL_DEDUP_EN
    ,
    output logic                           dup
`endif
);

    logic [NUM_LANES-1:0][ASCII_W-1:0] lane;

    assign data = lane;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrEn <= '0;
            lane <= '0;
        end else if (clr) begin
            wrEn <= '0;
            lane <= '0;
        end else if (we) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (slot == SLOT_W'(i)) begin
                    wrEn[i] <= 1'b1;
                    lane[i] <= din;
                end
            end
        end
    end

`ifdef TABLE_LOAD_CTRL_DEDUP_EN
    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            dup = dup | (wrEn[i] && lane[i] == din);
        end
    end
`endif

endmodule

// File: rtl/table_load_ctrl.sv
// table_load_ctrl: packs a valid/ready byte stream into TableBuilder lanes, strobes start and waits for done.
// TABLE_LOAD_CTRL_DEDUP_EN drops symbols already present in an enabled lane during FILL.
module table_load_ctrl
    import table_load_pkg::*;
#(
    parameter int NUM_LANES    = 6,
    parameter int START_CYCLES = 2,
    parameter int TIMEOUT      = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [ASCII_W-1:0]            in_data,
    input  logic                          in_last,
    output logic                          in_ready,
    output logic [NUM_LANES-1:0]          tb_wr_en,
    output logic [NUM_LANES*ASCII_W-1:0]  tb_wr_ascii,
    output logic                          tb_start,
    input  logic                          tb_done,
    output logic                          busy,
    output logic [15:0]                   batch_count,
    output logic                          err_timeout
);

    localparam int SLOT_W  = clog2(NUM_LANES);
    localparam int TIMER_W = clog2(TIMEOUT + 1);
    localparam int START_W = clog2(START_CYCLES + 1);

    loadState               state, stateNext;
    logic [SLOT_W-1:0]      slot, slotNext, wrSlot;
    logic [START_W-1:0]     startCnt, startCntNext;
    logic [TIMER_W-1:0]     timer, timerNext;
    logic                   xfer, store, laneClr, isDup, doneHit, timeoutHit;

    // Gate with rst_n so in_ready reads 0 while reset is held.
    assign in_ready = rst_n && (state == IDLE || state == FILL);
    assign xfer     = in_valid && in_ready;
    assign busy     = state != IDLE;
    assign tb_start = state == START;
    assign wrSlot   = state == FILL ? slot : '0;

    always_comb begin
        stateNext    = state;
        slotNext     = slot;
        startCntNext = startCnt;
        timerNext    = timer;
        store        = 1'b0;
        laneClr      = 1'b0;
        doneHit      = 1'b0;
        timeoutHit   = 1'b0;
        case (state)
            IDLE: begin
                slotNext     = '0;
                startCntNext = '0;
                if (xfer) begin
                    store     = 1'b1;
                    slotNext  = SLOT_W'(1);
                    stateNext = in_last ? START : FILL;
                end
            end
            FILL: begin
                if (xfer) begin
                    store     = !isDup;
                    slotNext  = slot + SLOT_W'(store);
                    stateNext = (in_last || (store && slot == SLOT_W'(NUM_LANES - 1))) ? START : FILL;
                end
            end
            START: begin
                startCntNext = startCnt + 1'b1;
                timerNext    = '0;
                if (startCnt == START_W'(START_CYCLES - 1))
                    stateNext = WAIT;
            end
            WAIT: begin
                // A done arriving on the timeout cycle takes priority.
                doneHit    = tb_done;
                timeoutHit = !tb_done && timer == TIMER_W'(TIMEOUT - 1);
                laneClr    = doneHit || timeoutHit;
                timerNext  = timer + 1'b1;
                slotNext   = '0;
                stateNext  = laneClr ? IDLE : WAIT;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            slot        <= '0;
            startCnt    <= '0;
            timer       <= '0;
            batch_count <= '0;
            err_timeout <= 1'b0;
        end else begin
            state       <= stateNext;
            slot        <= slotNext;
            startCnt    <= startCntNext;
            timer       <= timerNext;
            batch_count <= batch_count + 16'(doneHit);
            err_timeout <= err_timeout | timeoutHit;
        end
    end

    table_load_lanes #(
        .NUM_LANES(NUM_LANES),
        .SLOT_W   (SLOT_W)
    ) lanes (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (store),
        .slot (wrSlot),
        .din  (in_data),
        .clr  (laneClr),
        .wrEn (tb_wr_en),
        .data (tb_wr_ascii)
`ifdef TABLE_LOAD_CTRL_DEDUP_EN
        ,
        .dup  (isDup)
`endif
    );

`ifndef TABLE_LOAD_CTRL_DEDUP_EN
    assign isDup = 1'b0;
`endif

endmodule

// File: tb/tb_table_load_ctrl.sv
// tb_table_load_ctrl: directed bench for table_load_ctrl with immediate-assertion checks.
module tb_table_load_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_last = 1'b0;
    logic        tb_done = 1'b0;
    logic        in_ready;
    logic [5:0]  tb_wr_en;
    logic [47:0] tb_wr_ascii;
    logic        tb_start;
    logic        busy;
    logic [15:0] batch_count;
    logic        err_timeout;

    int checks = 0;
    int errors = 0;
    int starts;
    int cyc;

    always #5 clk = ~clk;

    table_load_ctrl #(
        .NUM_LANES   (6),
        .START_CYCLES(2),
        .TIMEOUT     (255)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .tb_wr_en   (tb_wr_en),
        .tb_wr_ascii(tb_wr_ascii),
        .tb_start   (tb_start),
        .tb_done    (tb_done),
        .busy       (busy),
        .batch_count(batch_count),
        .err_timeout(err_timeout)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        chk("send_ready", 64'(in_ready), 64'h1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic pulseDone();
        tb_done = 1'b1;
        step();
        tb_done = 1'b0;
    endtask

    initial begin
        #3;
        chk("rst_ready", 64'(in_ready), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_start", 64'(tb_start), 64'h0);
        chk("rst_wren", 64'(tb_wr_en), 64'h0);
        chk("rst_ascii", 64'(tb_wr_ascii), 64'h0);
        chk("rst_count", 64'(batch_count), 64'h0);
        chk("rst_err", 64'(err_timeout), 64'h0);
        #20 rst_n = 1'b1;
        step();
        chk("idle_ready", 64'(in_ready), 64'h1);

        for (int i = 1; i <= 5; i++) send(8'(i), 1'b0);
        chk("full_nostart", 64'(tb_start), 64'h0);
        chk("full_partial_wren", 64'(tb_wr_en), 64'h1f);
        send(8'd6, 1'b1);
        chk("full_wren", 64'(tb_wr_en), 64'h3f);
        chk("full_ascii", 64'(tb_wr_ascii), 64'h060504030201);
        chk("full_start1", 64'(tb_start), 64'h1);
        chk("full_ready0", 64'(in_ready), 64'h0);
        step();
        chk("full_start2", 64'(tb_start), 64'h1);
        step();
        chk("full_start_end", 64'(tb_start), 64'h0);
        chk("full_wait_busy", 64'(busy), 64'h1);
        chk("full_wait_wren", 64'(tb_wr_en), 64'h3f);
        repeat (9) step();
        pulseDone();
        chk("full_count", 64'(batch_count), 64'h1);
        chk("full_busy", 64'(busy), 64'h0);
        chk("full_ready", 64'(in_ready), 64'h1);
        chk("full_wren_clr", 64'(tb_wr_en), 64'h0);
        pulseDone();
        chk("idle_done_ignored", 64'(batch_count), 64'h1);

        send(8'h41, 1'b0);
        send(8'h42, 1'b1);
        chk("short_wren", 64'(tb_wr_en), 64'h03);
        chk("short_ascii", 64'(tb_wr_ascii), 64'h4241);
        starts = 0;
        for (int i = 0; i < 6; i++) begin
            starts += int'(tb_start);
            step();
        end
        chk("short_start_len", 64'(starts), 64'h2);
        pulseDone();
        chk("short_count", 64'(batch_count), 64'h2);

        in_valid = 1'b1;
        in_data  = 8'h11;
        in_last  = 1'b1;
        step();
        in_data = 8'h22;
        chk("bp_ready_start", 64'(in_ready), 64'h0);
        chk("bp_ascii_start", 64'(tb_wr_ascii), 64'h11);
        repeat (4) step();
        chk("bp_ready_wait", 64'(in_ready), 64'h0);
        chk("bp_ascii_wait", 64'(tb_wr_ascii), 64'h11);
        chk("bp_wren_wait", 64'(tb_wr_en), 64'h01);
        pulseDone();
        chk("bp_count", 64'(batch_count), 64'h3);
        chk("bp_ready_idle", 64'(in_ready), 64'h1);
        step();
        chk("bp_next_ascii", 64'(tb_wr_ascii), 64'h22);
        chk("bp_next_start", 64'(tb_start), 64'h1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        step();
        step();
        pulseDone();
        chk("bp_count2", 64'(batch_count), 64'h4);

        send(8'h55, 1'b1);
        cyc = 0;
        while (busy && cyc < 400) begin
            step();
            cyc++;
        end
        chk("to_cycles", 64'(cyc), 64'd257);
        chk("to_err", 64'(err_timeout), 64'h1);
        chk("to_count", 64'(batch_count), 64'h4);
        chk("to_wren", 64'(tb_wr_en), 64'h0);
        chk("to_ascii", 64'(tb_wr_ascii), 64'h0);

        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        chk("mid_wren", 64'(tb_wr_en), 64'h07);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_wren", 64'(tb_wr_en), 64'h0);
        chk("mid_rst_ascii", 64'(tb_wr_ascii), 64'h0);
        chk("mid_rst_busy", 64'(busy), 64'h0);
        chk("mid_rst_err", 64'(err_timeout), 64'h0);
        chk("mid_rst_count", 64'(batch_count), 64'h0);
        starts = 0;
        repeat (2) begin
            step();
            starts += int'(tb_start);
        end
        #3 rst_n = 1'b1;
        repeat (4) begin
            step();
            starts += int'(tb_start);
        end
        chk("mid_no_start", 64'(starts), 64'h0);
        chk("mid_idle", 64'(busy), 64'h0);

        send(8'h66, 1'b1);
        repeat (256) step();
        chk("coin_busy", 64'(busy), 64'h1);
        chk("coin_err_pre", 64'(err_timeout), 64'h0);
        pulseDone();
        chk("coin_err", 64'(err_timeout), 64'h0);
        chk("coin_count", 64'(batch_count), 64'h1);
        chk("coin_busy_end", 64'(busy), 64'h0);

        send(8'h07, 1'b0);
        send(8'h07, 1'b0);
        send(8'h08, 1'b1);
`ifdef TABLE_LOAD_CTRL_DEDUP_EN
        chk("dup_wren", 64'(tb_wr_en), 64'h03);
        chk("dup_ascii", 64'(tb_wr_ascii), 64'h0807);
`else
        chk("dup_wren", 64'(tb_wr_en), 64'h07);
        chk("dup_ascii", 64'(tb_wr_ascii), 64'h080707);
`endif
        chk("dup_start", 64'(tb_start), 64'h1);
        step();
        step();
        pulseDone();
        chk("dup_count", 64'(batch_count), 64'h2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
